// File: rtl/lfsr_trigger_gen.sv
// Pseudo-random trigger source: a Galois LFSR compared against a threshold fires a
// one-cycle trigger, then a fixed holdoff guarantees low time before the next one.
module lfsr_trigger_gen #(
  parameter int unsigned        LFSR_W  = 16,
  parameter logic [LFSR_W-1:0]  TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0]  SEED    = 16'hACE1,
  parameter int unsigned        HOLDOFF = 4,
  parameter int unsigned        CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_seed,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] threshold,
  input  logic              clear_count,
  output logic              pulse_out,
  output logic              holdoff,
  output logic [LFSR_W-1:0] lfsr_state,
  output logic [CNT_W-1:0]  pulse_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFire = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [7:0] HoldLoad = 8'(HOLDOFF);

  logic [1:0]        state_q, state_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // A zero seed would lock the LFSR at zero, so the reset seed is substituted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_seed) begin
      lfsr_d = (seed == '0) ? SEED : seed;
    end else if (enable) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      StIdle: begin
        if (enable && (lfsr_q <= threshold)) begin
          state_d = StFire;
        end
      end
      StFire: begin
        hold_cnt_d = HoldLoad;
        state_d    = StHold;
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q - 8'd1;
        if (hold_cnt_q <= 8'd1) begin
          hold_cnt_d = '0;
          state_d    = StIdle;
        end
      end
      default: begin
        state_d    = StIdle;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (clear_count) begin
      count_d = '0;
    end else if ((state_q == StFire) && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      lfsr_q     <= SEED;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
    end
  end

  assign pulse_out   = (state_q == StFire);
  assign holdoff     = (state_q == StFire) || (state_q == StHold);
  assign lfsr_state  = lfsr_q;
  assign pulse_count = count_q;

endmodule

// File: tb/tb_lfsr_trigger_gen.sv
// Directed bench for lfsr_trigger_gen; inputs change and outputs are sampled on the
// falling edge, so each sample reflects the preceding rising edge.
module tb_lfsr_trigger_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load_seed;
  logic [15:0] seed;
  logic [15:0] threshold;
  logic        clear_count;
  logic        pulse_out, pulse_out_s;
  logic        holdoff, holdoff_s;
  logic [15:0] lfsr_state, lfsr_state_s;
  logic [15:0] pulse_count;
  logic [3:0]  pulse_count_s;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  lfsr_trigger_gen dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load_seed   (load_seed),
    .seed        (seed),
    .threshold   (threshold),
    .clear_count (clear_count),
    .pulse_out   (pulse_out),
    .holdoff     (holdoff),
    .lfsr_state  (lfsr_state),
    .pulse_count (pulse_count)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  lfsr_trigger_gen #(.CNT_W(4)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load_seed   (load_seed),
    .seed        (seed),
    .threshold   (threshold),
    .clear_count (clear_count),
    .pulse_out   (pulse_out_s),
    .holdoff     (holdoff_s),
    .lfsr_state  (lfsr_state_s),
    .pulse_count (pulse_count_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  highs;
    int  pat_err;
    int  idle_cyc;
    int  fires;
    int  pct;
    bit  seen;
    bit  adj;
    logic        prev;
    logic [15:0] frozen;

    reset = 1'b1; enable = 1'b0; load_seed = 1'b0; seed = '0;
    threshold = '0; clear_count = 1'b0;
    step(2);
    check("rst_lfsr", 32'(lfsr_state), 32'hACE1);
    check("rst_pulse", 32'(pulse_out), 32'h0);
    check("rst_holdoff", 32'(holdoff), 32'h0);
    check("rst_count", 32'(pulse_count), 32'h0);

    // Reset asserted in the middle of HOLD
    reset = 1'b0; threshold = 16'hFFFF; enable = 1'b1;
    step(1);
    check("fire_latency", 32'(pulse_out), 32'h1);
    check("fire_holdoff", 32'(holdoff), 32'h1);
    step(1);
    check("hold_pulse_low", 32'(pulse_out), 32'h0);
    check("hold_holdoff", 32'(holdoff), 32'h1);
    check("hold_count", 32'(pulse_count), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("midrst_pulse", 32'(pulse_out), 32'h0);
    check("midrst_holdoff", 32'(holdoff), 32'h0);
    check("midrst_lfsr", 32'(lfsr_state), 32'hACE1);
    check("midrst_count", 32'(pulse_count), 32'h0);
    step(1);
    reset = 1'b0; enable = 1'b0; threshold = '0;
    step(1);

    // Known sequence from seed 1
    seed = 16'h0001; load_seed = 1'b1; enable = 1'b1;
    step(1);
    load_seed = 1'b0;
    check("seq0", 32'(lfsr_state), 32'h0001);
    step(1); check("seq1", 32'(lfsr_state), 32'hB400);
    step(1); check("seq2", 32'(lfsr_state), 32'h5A00);
    step(1); check("seq3", 32'(lfsr_state), 32'h2D00);
    step(1); check("seq4", 32'(lfsr_state), 32'h1680);

    // Zero seed load, then threshold 0 never fires
    seed = '0; load_seed = 1'b1;
    step(1);
    load_seed = 1'b0;
    check("zero_seed", 32'(lfsr_state), 32'hACE1);
    seen = 1'b0; adj = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      if (lfsr_state == '0) seen = 1'b1;
      if (pulse_out) adj = 1'b1;
    end
    check("lfsr_nonzero", 32'(seen), 32'h0);
    check("thr0_no_fire", 32'(adj), 32'h0);
    check("thr0_count", 32'(pulse_count), 32'h0);

    // Maximum rate: one high in every six cycles
    threshold = 16'hFFFF;
    highs = 0; pat_err = 0; adj = 1'b0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (pulse_out) highs++;
      if (pulse_out !== ((i % 6) == 0)) pat_err++;
      if (pulse_out && prev) adj = 1'b1;
      prev = pulse_out;
    end
    check("max_highs", 32'(highs), 32'd10);
    check("max_pattern", 32'(pat_err), 32'd0);
    check("max_adjacent", 32'(adj), 32'h0);
    check("max_count", 32'(pulse_count), 32'd10);

    // Half-probability threshold
    threshold = 16'h7FFF;
    idle_cyc = 0; fires = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1);
      if (!holdoff) idle_cyc++;
      if (pulse_out) fires++;
    end
    pct = (idle_cyc > 0) ? (fires * 100) / idle_cyc : 0;
    check("half_rate", 32'((pct >= 45) && (pct <= 55)), 32'h1);

    // Enable dropped during HOLD
    threshold = 16'hFFFF;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (pulse_out) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_fire", 32'(seen), 32'h1);
    enable = 1'b0;
    frozen = lfsr_state;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("hold_completes", 32'(holdoff), 32'h1);
    end
    step(1);
    check("back_idle", 32'(holdoff), 32'h0);
    adj = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pulse_out || holdoff) adj = 1'b1;
    end
    check("disabled_no_fire", 32'(adj), 32'h0);
    check("lfsr_frozen", 32'(lfsr_state), 32'(frozen));

    // clear_count coincident with FIRE
    enable = 1'b1;
    step(1);
    check("reenable_fire", 32'(pulse_out), 32'h1);
    clear_count = 1'b1; enable = 1'b0;
    step(1);
    clear_count = 1'b0;
    check("clear_vs_fire", 32'(pulse_count), 32'h0);
    check("clear_vs_fire_s", 32'(pulse_count_s), 32'h0);
    step(5);

    // Saturation on the narrow counter
    enable = 1'b1;
    highs = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (pulse_out) highs++;
    end
    enable = 1'b0;
    step(1);
    check("count_tracks", 32'(pulse_count), 32'(highs));
    check("sat_count", 32'(pulse_count_s), 32'hF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
